prog_sequencer: RTL and testbench

- Instruction source for the mini CPU datapath. It is the producer end of the control interface that the control unit drives today.
- The host loads a small program into an internal instruction memory and pulses start.
- The block then fetches instructions sequentially and issues decoded fields (alu_op, write_reg, read_reg1, read_reg2) over a valid/ready handshake to the register-file/ALU execution side.
- It raises done after the last instruction is accepted.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/prog_sequencer_if.sv | 20 ++
 rtl/prog_mem.sv | 23 ++
 rtl/prog_sequencer.sv | 140 ++++++++++++++
 tb/tb_prog_sequencer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared mini-CPU definitions: instruction field layout, ALU opcodes, sequencer states.
package cpu_pkg;

  localparam int unsigned OP_MSB = 7;
  localparam int unsigned OP_LSB = 6;
  localparam int unsigned WR_MSB = 5;
  localparam int unsigned WR_LSB = 4;
  localparam int unsigned R1_MSB = 3;
  localparam int unsigned R1_LSB = 2;
  localparam int unsigned R2_MSB = 1;
  localparam int unsigned R2_LSB = 0;
  localparam int unsigned INSTR_BITS = OP_MSB + 1;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] write_reg;
    logic [1:0] read_reg1;
    logic [1:0] read_reg2;
  } instr_t;

  // Split a raw instruction word into its decoded fields.
  function automatic instr_t decode_instr(input logic [INSTR_BITS-1:0] word);
    instr_t f;
    f.alu_op    = word[OP_MSB:OP_LSB];
    f.write_reg = word[WR_MSB:WR_LSB];
    f.read_reg1 = word[R1_MSB:R1_LSB];
    f.read_reg2 = word[R2_MSB:R2_LSB];
    return f;
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Decoded-instruction handshake between the sequencer and the execution side.
interface prog_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] alu_op;
  logic [1:0] write_reg;
  logic [1:0] read_reg1;
  logic [1:0] read_reg2;
  logic       reg_write;

  modport master (
    output instr_valid, alu_op, write_reg, read_reg1, read_reg2, reg_write,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, alu_op, write_reg, read_reg1, read_reg2, reg_write,
    output instr_ready
  );
endinterface

// File: rtl/prog_mem.sv
// Program store: synchronous write, synchronous read with enable; contents are never reset.
module prog_mem #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned INSTR_W = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [INSTR_W-1:0] mem [DEPTH];

  // Same-edge read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: runs a host-loaded program, issuing decoded instructions over valid/ready.
module prog_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               start,
  prog_sequencer_if.master   ibus,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done
);
  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

  state_e             state, state_next;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]  pc_d;
  instr_t             fields_q, fields_d;
  logic               valid_q, valid_d;
  logic               busy_d, done_d;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [INSTR_W-1:0] rd_data;
  logic               accept_c;
  logic               last_c;
  logic [LEN_W-1:0]   len_in_c;

  // The next word is read one cycle ahead so it is waiting in the memory register during FETCH.
  prog_mem #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign accept_c = valid_q & ibus.instr_ready;
  assign last_c   = (LEN_W'(pc) == (len_q - LEN_W'(1)));
  assign len_in_c = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (prog_len == '0) ? DONE : FETCH;
      end
      FETCH: state_next = ISSUE;
      ISSUE: begin
        if (accept_c) state_next = last_c ? DONE : FETCH;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values for pc, length, fields and status outputs, plus the memory read request.
  always_comb begin
    len_d    = len_q;
    pc_d     = pc;
    fields_d = fields_q;
    valid_d  = valid_q;
    rd_en    = 1'b0;
    rd_addr  = pc;
    case (state)
      IDLE: begin
        if (start) begin
          len_d   = len_in_c;
          pc_d    = '0;
          rd_en   = (prog_len != '0);
          rd_addr = '0;
        end
      end
      FETCH: begin
        fields_d = decode_instr(rd_data);
        valid_d  = 1'b1;
      end
      ISSUE: begin
        if (accept_c) begin
          valid_d = 1'b0;
          if (last_c) begin
            pc_d = '0;
          end else begin
            pc_d    = pc + ADDR_W'(1);
            rd_en   = 1'b1;
            rd_addr = pc + ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_next == FETCH) || (state_next == ISSUE);
    done_d = (state_next == DONE);
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= '0;
      len_q    <= '0;
      fields_q <= '0;
      valid_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      pc       <= pc_d;
      len_q    <= len_d;
      fields_q <= fields_d;
      valid_q  <= valid_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  assign ibus.instr_valid = valid_q;
  assign ibus.alu_op      = fields_q.alu_op;
  assign ibus.write_reg   = fields_q.write_reg;
  assign ibus.read_reg1   = fields_q.read_reg1;
  assign ibus.read_reg2   = fields_q.read_reg2;
  assign ibus.reg_write   = accept_c;
endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: expected {pc, word} pairs are queued per run and popped on each accept.
module tb_prog_sequencer;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned INSTR_W = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic [ADDR_W:0]    prog_len;
  logic               start;
  logic [ADDR_W-1:0]  pc;
  logic               busy;
  logic               done;

  prog_sequencer_if bus ();

  prog_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .prog_len  (prog_len),
    .start     (start),
    .ibus      (bus),
    .pc        (pc),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  model [16];
  logic [11:0] exp_q [$];

  int stall_cfg = 0;
  int ms1 = -1;
  int ms2 = -1;
  int ld_cyc = -1;
  logic [3:0] ld_a = '0;
  logic [7:0] ld_d = '0;

  int first_v;
  int done_cyc;
  int n_done;

  function automatic logic [7:0] cur_word();
    return {bus.alu_op, bus.write_reg, bus.read_reg1, bus.read_reg2};
  endfunction

  task automatic load_word(input logic [3:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    model[a] = d;
  endtask

  task automatic push_prog(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({4'(i), model[i]});
  endtask

  // Starts a run at cycle 0 and checks every issue against the scoreboard until done settles.
  task automatic run_prog(input string name, input logic [4:0] len, input int max_cyc);
    int stalls_left;
    bit hold;
    logic [7:0] prev_word;
    logic [11:0] e;
    stalls_left = stall_cfg; hold = 1'b0; prev_word = '0;
    first_v = -1; done_cyc = -1; n_done = 0;
    prog_len = len; start = 1'b1; bus.instr_ready = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (done) begin n_done++; if (done_cyc < 0) done_cyc = c; end
      if (bus.instr_valid) begin
        if (first_v < 0) first_v = c;
        n_cmp++;
        if (bus.reg_write !== bus.instr_ready || busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s strobe c=%0d: reg_write=%b busy=%b, required reg_write=%b busy=1",
                   name, c, bus.reg_write, busy, bus.instr_ready);
        end
        if (hold) begin
          n_cmp++;
          if (cur_word() !== prev_word) begin
            n_err++;
            $display("FAIL %s hold c=%0d: word=%h, required %h", name, c, cur_word(), prev_word);
          end
        end
        if (bus.instr_ready) begin
          hold = 1'b0;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s extra issue c=%0d: pc=%0d word=%h, required none", name, c, pc, cur_word());
          end else begin
            e = exp_q.pop_front();
            if (pc !== e[11:8] || cur_word() !== e[7:0]) begin
              n_err++;
              $display("FAIL %s issue c=%0d: pc=%0d word=%h, required pc=%0d word=%h",
                       name, c, pc, cur_word(), e[11:8], e[7:0]);
            end
          end
        end else begin
          hold = 1'b1;
          prev_word = cur_word();
        end
      end else begin
        hold = 1'b0;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      @(posedge clk); #1;
      start     = (c + 1 == ms1) || (c + 1 == ms2);
      load_en   = (c + 1 == ld_cyc);
      load_addr = ld_a;
      load_data = ld_d;
      prog_len  = ~len;
      if (bus.instr_valid && stalls_left > 0) begin
        bus.instr_ready = 1'b0;
        stalls_left--;
      end else begin
        bus.instr_ready = 1'b1;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; load_en = 1'b0; bus.instr_ready = 1'b1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s leftover: %0d issues missing, required 0", name, exp_q.size());
    end
    exp_q.delete();
    n_cmp++;
    if (pc !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle after: pc=%0d busy=%b done=%b, required 0 0 0", name, pc, busy, done);
    end
    stall_cfg = 0; ms1 = -1; ms2 = -1; ld_cyc = -1;
  endtask

  task automatic check_timing(input string name, input int fv, input int dc);
    n_cmp++;
    if (first_v != fv || done_cyc != dc || n_done != 1) begin
      n_err++;
      $display("FAIL %s timing: first_valid=%0d done_cycle=%0d done_pulses=%0d, required %0d %0d 1",
               name, first_v, done_cyc, n_done, fv, dc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    prog_len = '0; start = 1'b0; bus.instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.instr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pc !== 4'd0) begin
      n_err++;
      $display("FAIL reset status: valid=%b busy=%b done=%b pc=%0d, required 0 0 0 0",
               bus.instr_valid, busy, done, pc);
    end
    n_cmp++;
    if (cur_word() !== 8'h00 || bus.reg_write !== 1'b0) begin
      n_err++;
      $display("FAIL reset fields: word=%h reg_write=%b, required 00 0", cur_word(), bus.reg_write);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    load_word(4'd0, 8'h1B);
    load_word(4'd1, 8'hE4);
    push_prog(2);
    run_prog("basic", 5'd2, 40);
    check_timing("basic", 2, 5);
  endtask

  task automatic test_stall();
    push_prog(2);
    stall_cfg = 5;
    run_prog("stall", 5'd2, 40);
    check_timing("stall", 2, 10);
  endtask

  task automatic test_zero_len();
    run_prog("zero_len", 5'd0, 20);
    check_timing("zero_len", -1, 1);
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) load_word(4'(i), 8'(i));
    push_prog(16);
    run_prog("full16", 5'd16, 80);
    check_timing("full16", 2, 33);
    push_prog(16);
    run_prog("clamp31", 5'd31, 80);
    check_timing("clamp31", 2, 33);
  endtask

  task automatic test_collision();
    load_word(4'd0, 8'h1B);
    load_word(4'd1, 8'hE4);
    push_prog(2);
    ld_cyc = 3; ld_a = 4'd1; ld_d = 8'h3C;
    run_prog("collide", 5'd2, 40);
    check_timing("collide", 2, 5);
    model[1] = 8'h3C;
    push_prog(2);
    run_prog("after_collide", 5'd2, 40);
    check_timing("after_collide", 2, 5);
  endtask

  task automatic test_back_to_back();
    load_word(4'd2, 8'h96);
    load_word(4'd3, 8'h11);
    model[3] = 8'hA5;
    push_prog(4);
    ld_cyc = 2; ld_a = 4'd3; ld_d = 8'hA5;
    ms1 = 3; ms2 = 9;
    run_prog("busy_start", 5'd4, 60);
    check_timing("busy_start", 2, 9);
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    prog_len = 5'd4; start = 1'b1; bus.instr_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (bus.instr_valid && pc == 4'd1) begin found = 1'b1; break; end
    end
    bus.instr_ready = 1'b0;
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL reset_mid reach: pc=1 issue not seen, required within 20 cycles");
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.instr_valid !== 1'b0 || busy !== 1'b0 || pc !== 4'd0 || bus.reg_write !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid async: valid=%b busy=%b pc=%0d reg_write=%b, required 0 0 0 0",
               bus.instr_valid, busy, pc, bus.reg_write);
    end
    @(posedge clk); #1;
    reset = 1'b1; bus.instr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.instr_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid resume: valid=%b busy=%b, required 0 0", bus.instr_valid, busy);
    end
    push_prog(2);
    run_prog("after_reset", 5'd2, 40);
    check_timing("after_reset", 2, 5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_full();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
